md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It holds the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Exports Busy. The D-stage stall logic combines Start|Busy with a decoded md-type D instruction (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) to freeze PC and IF/ID and flush ID/EX.
- HI/LO values feed the E-stage result mux for mfhi/mflo.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_calc.sv | 50 +++++
 rtl/md_unit.sv | 92 +++++++++
 tb/tb_md_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and default busy-period lengths.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int CNT_W           = 16;

   function automatic logic isMultOp(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: 64-bit product or {remainder, quotient} for the
// selected operation, plus a flag for division by zero.
module md_calc
   import md_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic [63:0] result_o,
   output logic        divZero_o
);

   logic        signedDiv;
   logic        negA;
   logic        negB;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [31:0] divisor;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] quotOut;
   logic [31:0] remOut;

   // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to
   // 0x80000000 instead of hitting host-dependent overflow behaviour.
   always_comb begin
      signedDiv = (op_i == MD_DIV);
      negA      = signedDiv & a_i[31];
      negB      = signedDiv & b_i[31];
      magA      = negA ? (~a_i + 32'd1) : a_i;
      magB      = negB ? (~b_i + 32'd1) : b_i;
      divisor   = (b_i == 32'd0) ? 32'd1 : magB;
      quot      = magA / divisor;
      rem       = magA % divisor;
      quotOut   = (negA ^ negB) ? (~quot + 32'd1) : quot;
      remOut    = negA ? (~rem + 32'd1) : rem;
      result_o  = 64'd0;
      divZero_o = 1'b0;
      case (op_i)
         MD_MULT:  result_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
         MD_MULTU: result_o = {32'd0, a_i} * {32'd0, b_i};
         MD_DIV, MD_DIVU: begin
            result_o  = {remOut, quotOut};
            divZero_o = (b_i == 32'd0);
         end
         default: result_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed number
// of busy cycles and commits the shadowed result when the count expires.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      sHi_q;
   logic [31:0]      sLo_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic             busy_q;

   logic [63:0]      calcResult_d;
   logic             divZero_d;
   logic [CNT_W-1:0] cntLoad_d;

   md_calc u_calc (
      .a_i       (A),
      .b_i       (B),
      .op_i      (MDOp),
      .result_o  (calcResult_d),
      .divZero_o (divZero_d)
   );

   assign cntLoad_d = isMultOp(MDOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

   // The result is computed at acceptance and parked in sHI/sLO; HI/LO only
   // change when the busy window closes. Divide-by-zero re-commits old HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sHi_q   <= '0;
         sLo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  case (MDOp)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        sHi_q   <= divZero_d ? hi_q : calcResult_d[63:32];
                        sLo_q   <= divZero_d ? lo_q : calcResult_d[31:0];
                        cnt_q   <= cntLoad_d;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                     MD_MTHI: hi_q <= A;
                     MD_MTLO: lo_q <= A;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt_q > CNT_W'(1)) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  hi_q    <= sHi_q;
                  lo_q    <= sLo_q;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: busy-window lengths, mult/div results, HI/LO
// moves, divide by zero, mid-operation reset and starts ignored while busy.
module tb_md_unit;
   import md_pkg::*;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int compared = 0;
   int mismatched = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .Start (Start),
      .MDOp  (MDOp),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start = 1'b1; MDOp = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; MDOp = MD_NONE; A = '0; B = '0;
   endtask

   task automatic waitIdle(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; Start = 1'b0; MDOp = MD_NONE; A = '0; B = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
      compared++; if (HI !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hi: got %h expected 00000000", HI); end
      compared++; if (LO !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_lo: got %h expected 00000000", LO); end
   endtask

   task automatic test_mult;
      int n;
      startOp(MD_MULT, 32'hFFFFFFFE, 32'd3);
      waitIdle(n);
      compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL mult_cycles: got %0d expected 5", n); end
      compared++; if (HI !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL mult_hi: got %h expected FFFFFFFF", HI); end
      compared++; if (LO !== 32'hFFFFFFFA) begin mismatched++; $display("[TB] FAIL mult_lo: got %h expected FFFFFFFA", LO); end
   endtask

   task automatic test_multu;
      int n;
      startOp(MD_MULTU, 32'hFFFFFFFE, 32'd3);
      waitIdle(n);
      compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL multu_cycles: got %0d expected 5", n); end
      compared++; if (HI !== 32'h00000002) begin mismatched++; $display("[TB] FAIL multu_hi: got %h expected 00000002", HI); end
      compared++; if (LO !== 32'hFFFFFFFA) begin mismatched++; $display("[TB] FAIL multu_lo: got %h expected FFFFFFFA", LO); end
   endtask

   task automatic test_div;
      int n;
      startOp(MD_DIV, 32'hFFFFFFF9, 32'd2);
      waitIdle(n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL div_cycles: got %0d expected 10", n); end
      compared++; if (LO !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_lo: got %h expected FFFFFFFD", LO); end
      compared++; if (HI !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div_hi: got %h expected FFFFFFFF", HI); end
      startOp(MD_DIV, 32'd7, 32'hFFFFFFFE);
      waitIdle(n);
      compared++; if (LO !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_negdivisor_lo: got %h expected FFFFFFFD", LO); end
      compared++; if (HI !== 32'h00000001) begin mismatched++; $display("[TB] FAIL div_negdivisor_hi: got %h expected 00000001", HI); end
      startOp(MD_DIVU, 32'd100, 32'd7);
      waitIdle(n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL divu_cycles: got %0d expected 10", n); end
      compared++; if (LO !== 32'd14) begin mismatched++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", LO); end
      compared++; if (HI !== 32'd2) begin mismatched++; $display("[TB] FAIL divu_hi: got %h expected 00000002", HI); end
   endtask

   task automatic test_overflow;
      int n;
      startOp(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      waitIdle(n);
      compared++; if (LO !== 32'h80000000) begin mismatched++; $display("[TB] FAIL ovf_lo: got %h expected 80000000", LO); end
      compared++; if (HI !== 32'h00000000) begin mismatched++; $display("[TB] FAIL ovf_hi: got %h expected 00000000", HI); end
   endtask

   task automatic test_mthi_mtlo;
      startOp(MD_MTHI, 32'h12345678, 32'h0);
      compared++; if (HI !== 32'h12345678) begin mismatched++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", HI); end
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mthi_busy: got %b expected 0", Busy); end
      startOp(MD_MTLO, 32'hCAFEF00D, 32'h0);
      compared++; if (LO !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL mtlo_lo: got %h expected CAFEF00D", LO); end
      compared++; if (HI !== 32'h12345678) begin mismatched++; $display("[TB] FAIL mtlo_keeps_hi: got %h expected 12345678", HI); end
      startOp(MD_RSVD, 32'h1, 32'h1);
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rsvd_busy: got %b expected 0", Busy); end
      compared++; if (LO !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL rsvd_lo: got %h expected CAFEF00D", LO); end
      startOp(MD_NONE, 32'h1, 32'h1);
      compared++; if (HI !== 32'h12345678) begin mismatched++; $display("[TB] FAIL none_hi: got %h expected 12345678", HI); end
   endtask

   task automatic test_divzero;
      int n;
      startOp(MD_DIVU, 32'd7, 32'd0);
      waitIdle(n);
      compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL divzero_cycles: got %0d expected 10", n); end
      compared++; if (HI !== 32'h12345678) begin mismatched++; $display("[TB] FAIL divzero_hi: got %h expected 12345678", HI); end
      compared++; if (LO !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL divzero_lo: got %h expected CAFEF00D", LO); end
   endtask

   task automatic test_reset_midop;
      int n;
      startOp(MD_MULT, 32'd5, 32'd6);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy: got %b expected 0", Busy); end
      compared++; if (HI !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_hi: got %h expected 00000000", HI); end
      compared++; if (LO !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_lo: got %h expected 00000000", LO); end
      repeat (8) @(negedge clk);
      compared++; if (LO !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_late_lo: got %h expected 00000000", LO); end
      startOp(MD_MULT, 32'd5, 32'd6);
      waitIdle(n);
      compared++; if (LO !== 32'd30) begin mismatched++; $display("[TB] FAIL postreset_mult_lo: got %h expected 0000001e", LO); end
   endtask

   task automatic test_back_to_back;
      int n;
      startOp(MD_MTLO, 32'h00000055, 32'h0);
      startOp(MD_MULT, 32'd3, 32'd4);
      Start = 1'b1; MDOp = MD_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
      @(negedge clk);
      Start = 1'b1; MDOp = MD_MTLO; A = 32'h0000DEAD; B = 32'h0;
      @(negedge clk);
      Start = 1'b0; MDOp = MD_NONE; A = '0; B = '0;
      compared++; if (LO !== 32'h00000055) begin mismatched++; $display("[TB] FAIL busy_mtlo_lo: got %h expected 00000055", LO); end
      waitIdle(n);
      compared++; if (n !== 3) begin mismatched++; $display("[TB] FAIL busy_ignore_remaining: got %0d expected 3", n); end
      compared++; if (HI !== 32'h0) begin mismatched++; $display("[TB] FAIL busy_ignore_hi: got %h expected 00000000", HI); end
      compared++; if (LO !== 32'd12) begin mismatched++; $display("[TB] FAIL busy_ignore_lo: got %h expected 0000000c", LO); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_overflow();
      test_mthi_mtlo();
      test_divzero();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
